// File: rtl/ldtu_bsl_pkg.sv
// Shared definitions for the LiTe-DTU baseline subtraction stage:
// calibration FSM encoding and baseline mode selectors.
package ldtu_bsl_pkg;

    typedef enum logic [1:0] {
        BSL_IDLE   = 2'd0,
        BSL_ACCUM  = 2'd1,
        BSL_COMMIT = 2'd2
    } bsl_state_e;

    localparam logic BSL_MODE_MANUAL = 1'b0;
    localparam logic BSL_MODE_AUTO   = 1'b1;

endpackage

// File: rtl/ldtu_bsl_chan.sv
// One channel of the baseline subtractor: stage-1 capture of sample and
// baseline, stage-2 subtract with underflow flag and optional clamp to zero.
module ldtu_bsl_chan
    import ldtu_bsl_pkg::*;
#(
    parameter int unsigned DW = 12,
    parameter int unsigned BW = 8
) (
    input  logic          CLK,
    input  logic          reset,
    input  logic          in_valid,
    input  logic          s1_valid,
    input  logic          sat_en,
    input  logic [DW-1:0] sample,
    input  logic [BW-1:0] baseline,
    output logic [DW-1:0] data_out,
    output logic          underflow
);

    logic [DW-1:0] s1_data_q;
    logic [BW-1:0] s1_bsl_q;
    logic [DW:0]   bsl_ext;
    logic [DW:0]   diff;
    logic [DW-1:0] res_d;
    logic          uf_d;
    logic [DW-1:0] data_out_q;
    logic          underflow_q;

    // The extra top bit of the DW+1 bit difference is the borrow, i.e. underflow.
    always_comb begin
        bsl_ext           = '0;
        bsl_ext[BW-1:0]   = s1_bsl_q;
        diff              = {1'b0, s1_data_q} - bsl_ext;
        uf_d              = diff[DW];
        res_d             = (uf_d && sat_en) ? '0 : diff[DW-1:0];
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            s1_data_q   <= '0;
            s1_bsl_q    <= '0;
            data_out_q  <= '0;
            underflow_q <= 1'b0;
        end else begin
            if (in_valid) begin
                s1_data_q <= sample;
                s1_bsl_q  <= baseline;
            end
            if (s1_valid) begin
                data_out_q  <= res_d;
                underflow_q <= uf_d;
            end
        end
    end

    assign data_out  = data_out_q;
    assign underflow = underflow_q;

endmodule

// File: rtl/ldtu_bsl_sub_auto.sv
// Multi-channel baseline subtractor with manual or auto-calibrated per-channel
// baselines; the calibration averages 2^LOG2_NAVG valid samples per channel.
module ldtu_bsl_sub_auto
    import ldtu_bsl_pkg::*;
#(
    parameter int unsigned NCH       = 2,
    parameter int unsigned DW        = 12,
    parameter int unsigned BW        = 8,
    parameter int unsigned LOG2_NAVG = 4
) (
    input  logic              CLK,
    input  logic              reset,
    input  logic [NCH*DW-1:0] data_in,
    input  logic              data_valid,
    input  logic [NCH*BW-1:0] bsl_manual,
    input  logic              bsl_mode,
    input  logic              sat_en,
    input  logic              calib_start,
    output logic [NCH*DW-1:0] data_out,
    output logic              data_out_valid,
    output logic [NCH-1:0]    underflow,
    output logic [NCH*BW-1:0] bsl_auto,
    output logic              calib_busy,
    output logic              calib_done
);

    localparam int unsigned          AW       = DW + LOG2_NAVG;
    localparam logic [LOG2_NAVG-1:0] CNT_LAST = '1;
    localparam logic [AW:0]          RND      = (AW+1)'(1) << (LOG2_NAVG - 1);
    localparam logic [AW:0]          BSL_MAX  = (AW+1)'((1 << BW) - 1);

    bsl_state_e           state_q, state_d;
    logic [LOG2_NAVG-1:0] cnt_q;
    logic                 acc_clr;
    logic                 acc_en;
    logic                 commit;
    logic                 s1_valid_q;
    logic                 out_valid_q;

    always_comb begin
        state_d = state_q;
        acc_clr = 1'b0;
        acc_en  = 1'b0;
        commit  = 1'b0;
        case (state_q)
            BSL_IDLE: begin
                if (calib_start) begin
                    state_d = BSL_ACCUM;
                    acc_clr = 1'b1;
                end
            end
            BSL_ACCUM: begin
                // calib_start is deliberately not looked at here
                if (data_valid) begin
                    acc_en = 1'b1;
                    if (cnt_q == CNT_LAST) begin
                        state_d = BSL_COMMIT;
                    end
                end
            end
            BSL_COMMIT: begin
                commit  = 1'b1;
                state_d = BSL_IDLE;
            end
            default: begin
                state_d = BSL_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            state_q     <= BSL_IDLE;
            cnt_q       <= '0;
            s1_valid_q  <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            s1_valid_q  <= data_valid;
            out_valid_q <= s1_valid_q;
            if (acc_clr) begin
                cnt_q <= '0;
            end else if (acc_en) begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    for (genvar k = 0; k < NCH; k++) begin : g_chan
        logic [DW-1:0] sample;
        logic [AW-1:0] acc_q;
        logic [AW:0]   sum_rnd;
        logic [AW:0]   avg;
        logic [BW-1:0] bsl_q;
        logic [BW-1:0] bsl_d;
        logic [BW-1:0] bsl_eff;

        assign sample  = data_in[k*DW +: DW];
        // Round half up, then clip to the largest representable baseline.
        assign sum_rnd = {1'b0, acc_q} + RND;
        assign avg     = sum_rnd >> LOG2_NAVG;
        assign bsl_d   = (avg > BSL_MAX) ? '1 : avg[BW-1:0];
        assign bsl_eff = (bsl_mode == BSL_MODE_AUTO) ? bsl_q : bsl_manual[k*BW +: BW];

        always_ff @(posedge CLK) begin
            if (reset) begin
                acc_q <= '0;
                bsl_q <= '0;
            end else begin
                if (acc_clr) begin
                    acc_q <= '0;
                end else if (acc_en) begin
                    acc_q <= acc_q + AW'(sample);
                end
                if (commit) begin
                    bsl_q <= bsl_d;
                end
            end
        end

        assign bsl_auto[k*BW +: BW] = bsl_q;

        ldtu_bsl_chan #(
            .DW (DW),
            .BW (BW)
        ) u_chan (
            .CLK       (CLK),
            .reset     (reset),
            .in_valid  (data_valid),
            .s1_valid  (s1_valid_q),
            .sat_en    (sat_en),
            .sample    (sample),
            .baseline  (bsl_eff),
            .data_out  (data_out[k*DW +: DW]),
            .underflow (underflow[k])
        );
    end

    assign data_out_valid = out_valid_q;
    assign calib_busy     = (state_q != BSL_IDLE);
    assign calib_done     = (state_q == BSL_COMMIT);

endmodule

// File: tb/tb_ldtu_bsl_sub_auto.sv
// Scoreboard bench for ldtu_bsl_sub_auto: expected outputs are queued on every
// accepted sample and compared in order when data_out_valid appears.
module tb_ldtu_bsl_sub_auto;

    localparam int NCH = 2;
    localparam int DW  = 12;
    localparam int BW  = 8;

    logic              CLK = 1'b0;
    logic              reset;
    logic [NCH*DW-1:0] data_in;
    logic              data_valid;
    logic [NCH*BW-1:0] bsl_manual;
    logic              bsl_mode;
    logic              sat_en;
    logic              calib_start;
    logic [NCH*DW-1:0] data_out;
    logic              data_out_valid;
    logic [NCH-1:0]    underflow;
    logic [NCH*BW-1:0] bsl_auto;
    logic              calib_busy;
    logic              calib_done;

    int n_checks = 0;
    int n_fail   = 0;

    logic [NCH*BW-1:0]        model_auto;
    logic [NCH+NCH*DW-1:0]    sb_q[$];

    ldtu_bsl_sub_auto u_dut (
        .CLK            (CLK),
        .reset          (reset),
        .data_in        (data_in),
        .data_valid     (data_valid),
        .bsl_manual     (bsl_manual),
        .bsl_mode       (bsl_mode),
        .sat_en         (sat_en),
        .calib_start    (calib_start),
        .data_out       (data_out),
        .data_out_valid (data_out_valid),
        .underflow      (underflow),
        .bsl_auto       (bsl_auto),
        .calib_busy     (calib_busy),
        .calib_done     (calib_done)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // {underflow, result} for one channel
    function automatic logic [DW:0] exp_chan(input logic [DW-1:0] d, input logic [BW-1:0] b,
                                             input logic sat);
        logic [DW:0] diff;
        diff = {1'b0, d} - {{(DW-BW+1){1'b0}}, b};
        if (diff[DW] && sat) return {1'b1, {DW{1'b0}}};
        return diff;
    endfunction

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic send(input logic [DW-1:0] d0, input logic [DW-1:0] d1);
        logic [BW-1:0] b0, b1;
        logic [DW:0]   e0, e1;
        b0 = bsl_mode ? model_auto[BW-1:0]  : bsl_manual[BW-1:0];
        b1 = bsl_mode ? model_auto[2*BW-1:BW] : bsl_manual[2*BW-1:BW];
        e0 = exp_chan(d0, b0, sat_en);
        e1 = exp_chan(d1, b1, sat_en);
        data_in    = {d1, d0};
        data_valid = 1'b1;
        sb_q.push_back({e1[DW], e0[DW], e1[DW-1:0], e0[DW-1:0]});
        tick();
        data_valid = 1'b0;
    endtask

    task automatic pulse_start();
        calib_start = 1'b1;
        tick();
        calib_start = 1'b0;
    endtask

    // 16 samples: first 8 use a*, last 8 use b*; idle gaps every third sample
    task automatic calib(input logic [DW-1:0] a0, input logic [DW-1:0] b0,
                         input logic [DW-1:0] a1, input logic [DW-1:0] b1,
                         input logic [BW-1:0] e0, input logic [BW-1:0] e1,
                         input bit restart_mid);
        pulse_start();
        chk("calib_busy_start", {31'd0, calib_busy}, 32'd1);
        for (int i = 0; i < 16; i++) begin
            if (restart_mid && i == 5) pulse_start();
            if (i % 3 == 1) tick();
            send((i < 8) ? a0 : b0, (i < 8) ? a1 : b1);
            if (i == 14) chk("calib_done_early", {31'd0, calib_done}, 32'd0);
        end
        chk("calib_done_pulse", {31'd0, calib_done}, 32'd1);
        tick();
        chk("calib_done_width", {31'd0, calib_done}, 32'd0);
        chk("calib_busy_end", {31'd0, calib_busy}, 32'd0);
        chk("bsl_auto", {16'd0, bsl_auto}, {16'd0, e1, e0});
        model_auto = {e1, e0};
    endtask

    always @(negedge CLK) begin
        if (!reset && data_out_valid) begin
            if (sb_q.size() == 0) begin
                chk("sb_unexpected_valid", 32'd1, 32'd0);
            end else begin
                chk("sb_data", {6'd0, underflow, data_out}, {6'd0, sb_q.pop_front()});
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        reset       = 1'b1;
        data_in     = '0;
        data_valid  = 1'b0;
        bsl_manual  = {8'd50, 8'd20};
        bsl_mode    = 1'b0;
        sat_en      = 1'b1;
        calib_start = 1'b0;
        model_auto  = '0;
        tick();
        tick();
        chk("rst_data_out", {8'd0, data_out}, 32'd0);
        chk("rst_valid", {31'd0, data_out_valid}, 32'd0);
        chk("rst_underflow", {30'd0, underflow}, 32'd0);
        chk("rst_bsl_auto", {16'd0, bsl_auto}, 32'd0);
        chk("rst_busy_done", {30'd0, calib_busy, calib_done}, 32'd0);
        reset = 1'b0;
        tick();

        // Manual subtraction, latency 2, hold afterwards
        send(12'd100, 12'd60);
        chk("t1_valid_lat1", {31'd0, data_out_valid}, 32'd0);
        tick();
        chk("t1_valid_lat2", {31'd0, data_out_valid}, 32'd1);
        chk("t1_data", {8'd0, data_out}, {8'd0, 12'd10, 12'd80});
        chk("t1_uf", {30'd0, underflow}, 32'd0);
        tick();
        chk("t1_valid_drop", {31'd0, data_out_valid}, 32'd0);
        chk("t1_hold", {8'd0, data_out}, {8'd0, 12'd10, 12'd80});

        // Underflow with clamp, with wrap, and exact zero
        send(12'd10, 12'd50);
        tick();
        chk("t2_sat_data", {8'd0, data_out}, 32'd0);
        chk("t2_sat_uf", {30'd0, underflow}, 32'd1);
        sat_en = 1'b0;
        tick();
        send(12'd10, 12'd49);
        tick();
        chk("t2_wrap_data", {8'd0, data_out}, {8'd0, 12'd4095, 12'd4086});
        chk("t2_wrap_uf", {30'd0, underflow}, 32'd3);
        send(12'd20, 12'd50);
        tick();
        chk("t2_zero_data", {8'd0, data_out}, 32'd0);
        chk("t2_zero_uf", {30'd0, underflow}, 32'd0);
        sat_en = 1'b1;
        tick();

        // Auto calibration to 37, then use it
        calib(12'd37, 12'd37, 12'd37, 12'd37, 8'd37, 8'd37, 1'b0);
        bsl_mode = 1'b1;
        send(12'd100, 12'd100);
        tick();
        chk("t3_auto_data", {8'd0, data_out}, {8'd0, 12'd63, 12'd63});

        // Rounding half up on ch0, clip on ch1
        calib(12'd10, 12'd11, 12'd300, 12'd300, 8'd11, 8'd255, 1'b0);

        // Reset mid-calibration discards the partial accumulation
        pulse_start();
        for (int i = 0; i < 7; i++) send(12'd1000, 12'd1000);
        tick();
        tick();
        chk("t5_busy_pre", {31'd0, calib_busy}, 32'd1);
        chk("t5_sb_drained", sb_q.size(), 32'd0);
        reset = 1'b1;
        tick();
        chk("t5_rst_busy", {31'd0, calib_busy}, 32'd0);
        chk("t5_rst_bsl", {16'd0, bsl_auto}, 32'd0);
        chk("t5_rst_valid", {31'd0, data_out_valid}, 32'd0);
        reset      = 1'b0;
        model_auto = '0;
        tick();
        calib(12'd40, 12'd40, 12'd3, 12'd3, 8'd40, 8'd3, 1'b1);

        // Mode switch between back-to-back samples
        bsl_mode = 1'b0;
        send(12'd100, 12'd100);
        bsl_mode = 1'b1;
        send(12'd100, 12'd100);
        chk("t6_valid_a", {31'd0, data_out_valid}, 32'd1);
        chk("t6_manual", {8'd0, data_out}, {8'd0, 12'd50, 12'd80});
        tick();
        chk("t6_valid_b", {31'd0, data_out_valid}, 32'd1);
        chk("t6_auto", {8'd0, data_out}, {8'd0, 12'd97, 12'd60});

        tick();
        tick();
        tick();
        chk("sb_final_empty", sb_q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ldtu_bsl_sub_auto.md
Name: ldtu_bsl_sub_auto

Overview:
Parametrised, multi-channel baseline subtraction stage for the LiTe-DTU front end. It is the next generation of the per-gain baseline subtractor and adds:
- per-channel baselines;
- selectable manual or automatic (on-chip calibrated) baseline;
- underflow detection with optional clamp-to-zero;
- valid-qualified pipeline.

It sits between the ADC input capture and the compression/encoding stage, in the single CLK domain.

Parameters:
NCH, 2, number of ADC channels (gain_1, gain_10, ...)
DW, 12, sample width
BW, 8, baseline width (BW <= DW)
LOG2_NAVG, 4, log2 of samples averaged per auto-calibration (16)

Ports:
CLK  in  1  block clock; all logic on rising edge
reset  in  1  synchronous, active-high reset
data_in  in  NCH*DW  channel samples, channel k at [k*DW +: DW]
data_valid  in  1  data_in valid this cycle
bsl_manual  in  NCH*BW  manual baselines, channel k at [k*BW +: BW]
bsl_mode  in  1  0 = manual baseline, 1 = auto baseline
sat_en  in  1  1 = clamp negative results to 0, 0 = wrap mod 2^DW
calib_start  in  1  single-cycle pulse to start auto-calibration
data_out  out  NCH*DW  baseline-subtracted samples
data_out_valid  out  1  data_out valid
underflow  out  NCH  per-channel: sample < baseline; aligned with data_out
bsl_auto  out  NCH*BW  current auto-calibrated baselines
calib_busy  out  1  high in ACCUM and COMMIT
calib_done  out  1  one-cycle pulse on calibration commit

Behaviour:
Reset (reset=1 at a CLK edge):
- data_out, underflow, bsl_auto, accumulators and sample counter all clear to 0.
- data_out_valid, calib_busy and calib_done are 0.
- FSM returns to IDLE. This applies mid-calibration as well: any partial accumulation is discarded.

Pipeline (latency 2):
- Stage 1 registers data_in and the effective baseline for each channel when data_valid=1.
- Effective baseline = bsl_mode ? bsl_auto[k] : bsl_manual[k], taken from register contents in the acceptance cycle. A mode change therefore affects the next accepted sample only.
- Stage 2 registers the result. data_out_valid equals data_valid delayed by 2 cycles.
- data_out and underflow hold their values when no new sample is present.

Arithmetic (per channel):
- diff = {1'b0,d} - {1'b0,{(DW-BW){0}},b}, computed in DW+1 bits.
- underflow[k] = diff[DW].
- If underflow and sat_en=1: data_out = 0.
- Otherwise: data_out = diff[DW-1:0] (wrap).
- A result of exactly 0 is not an underflow.

Calibration FSM:
- IDLE: on calib_start=1, go to ACCUM; clear acc[k] (width DW+LOG2_NAVG) and cnt.
- ACCUM: on each cycle with data_valid=1, acc[k] += data_in[k] and cnt++.
  - On the valid sample with cnt == 2^LOG2_NAVG-1, go to COMMIT.
  - Cycles without data_valid do not advance.
  - calib_start is ignored while in ACCUM.
- COMMIT (exactly 1 cycle):
  - avg = (acc[k] + 2^(LOG2_NAVG-1)) >> LOG2_NAVG, i.e. round half up.
  - bsl_auto[k] = (avg > 2^BW-1) ? 2^BW-1 : avg[BW-1:0].
  - calib_done=1 for this cycle; next state IDLE.
  - New bsl_auto is visible from the following cycle.
  - calib_start is ignored in COMMIT.
- Subtraction continues uninterrupted during calibration, using the previous bsl_auto or manual value.
- calib_busy = (state != IDLE).

Decomposition:
- Shared package ldtu_bsl_pkg holds:
  - FSM state encoding: BSL_IDLE, BSL_ACCUM, BSL_COMMIT;
  - mode constants: BSL_MODE_MANUAL = 0, BSL_MODE_AUTO = 1.
- One sub-module, ldtu_bsl_chan:
  - contents: per-channel subtract, saturate and underflow logic, plus its stage-1/stage-2 registers;
  - instantiation: NCH copies via generate.
- FSM, counter and accumulators stay in the top level.

Test Plan:
1. Manual mode, bsl_manual={20,50}, data_in={100,60}, data_valid=1 -> 2 cycles later data_out={80,10}, data_out_valid=1, underflow=0.
2. Underflow: bsl=20, data=10.
   - sat_en=1 -> data_out=0, underflow=1.
   - sat_en=0 -> data_out=4086, underflow=1.
   - data=20 -> data_out=0, underflow=0.
3. Auto calibration: calib_start pulse, then 16 valid samples of 37, with idle gaps between some samples.
   - calib_done pulses exactly 1 cycle after the 16th valid sample; bsl_auto=37.
   - With bsl_mode=1, data 100 -> data_out=63.
4. Rounding and clip:
   - 8 samples of 10 plus 8 samples of 11 -> bsl_auto=11 (10.5 rounds up).
   - 16 samples of 300 -> bsl_auto=255.
5. reset=1 after 7 accumulated samples -> calib_busy=0, bsl_auto=0, data_out_valid=0 next cycle.
   - A new calib_start after reset requires a full 16 samples.
   - A second calib_start sent mid-ACCUM does not restart the count.
6. Switch bsl_mode 0->1 between two consecutive valid samples -> first output uses the manual baseline, second uses bsl_auto. No data_out_valid gaps.
